// File: rtl/digit_scan_selector.sv
// Time-multiplexed seven-segment digit selector with double-buffered digit codes.
// Define LEADING_ZERO_BLANK_EN to compile in leading-zero suppression.
module digit_scan_selector #(
  parameter  int DIGITS = 4,
  parameter  int DATA_W = 4,
  parameter  int DIV    = 50000,
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int PCNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     load_i,
  input  logic [DIGITS*DATA_W-1:0] n_i,
  input  logic [DIGITS-1:0]        blank_i,
  output logic [DIGITS-1:0]        sel_o,
  output logic [DATA_W-1:0]        h_o,
  output logic [IDX_W-1:0]         idx_o,
  output logic                     blank_o
);

  // state | meaning
  // RUN   | en_i was high last edge; outputs follow the scan
  // HOLD  | en_i was low last edge; display dark, pcnt/idx frozen
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t                   r_state;
  logic [DIGITS*DATA_W-1:0] r_sh_n;
  logic [DIGITS-1:0]        r_sh_blank;
  logic [PCNT_W-1:0]        r_pcnt;
  logic [IDX_W-1:0]         r_idx;
  logic [DIGITS-1:0]        r_sel;
  logic [DATA_W-1:0]        r_h;
  logic                     r_blank;

  logic                     w_tick;
  logic [IDX_W-1:0]         w_idx_nxt;
  logic [IDX_W-1:0]         w_tgt;
  logic [DIGITS-1:0]        w_supp;
  logic [DIGITS-1:0]        w_dark;
  logic                     w_tgt_dark;
  logic [DATA_W-1:0]        w_tgt_code;
  logic [DIGITS-1:0]        w_tgt_sel;

  assign w_tick    = en_i & (r_pcnt == PCNT_W'(DIV - 1));
  assign w_idx_nxt = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
  // Digit the outputs describe at this edge: the incoming one on a tick, else the held one.
  assign w_tgt     = w_tick ? w_idx_nxt : r_idx;

  always_comb begin
    w_supp = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic v_tail_zero;
      v_tail_zero = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
        v_tail_zero = v_tail_zero & (r_sh_n[k*DATA_W +: DATA_W] == '0);
        w_supp[k]   = v_tail_zero;
      end
    end
`endif
  end

  assign w_dark     = r_sh_blank | w_supp;
  assign w_tgt_dark = w_dark[w_tgt];
  assign w_tgt_code = r_sh_n[int'(w_tgt)*DATA_W +: DATA_W];
  assign w_tgt_sel  = DIGITS'(1) << w_tgt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= RUN;
      r_sh_n     <= '0;
      r_sh_blank <= '0;
      r_pcnt     <= '0;
      r_idx      <= '0;
      r_sel      <= DIGITS'(1);
      r_h        <= '0;
      r_blank    <= 1'b0;
    end else begin
      if (load_i) begin
        r_sh_n     <= n_i;
        r_sh_blank <= blank_i;
      end

      if (en_i) begin
        if (w_tick) begin
          r_pcnt <= '0;
          r_idx  <= w_idx_nxt;
        end else begin
          r_pcnt <= r_pcnt + PCNT_W'(1);
        end
      end

      case (r_state)
        RUN: begin
          if (!en_i) begin
            r_state <= HOLD;
            r_sel   <= '0;
            r_h     <= '0;
            r_blank <= 1'b1;
          end else if (w_tick) begin
            r_sel   <= w_tgt_dark ? '0 : w_tgt_sel;
            r_h     <= w_tgt_dark ? '0 : w_tgt_code;
            r_blank <= w_tgt_dark;
          end
        end
        HOLD: begin
          if (en_i) begin
            r_state <= RUN;
            r_sel   <= w_tgt_dark ? '0 : w_tgt_sel;
            r_h     <= w_tgt_dark ? '0 : w_tgt_code;
            r_blank <= w_tgt_dark;
          end
        end
        default: r_state <= HOLD;
      endcase
    end
  end

  assign sel_o   = r_sel;
  assign h_o     = r_h;
  assign blank_o = r_blank;
  assign idx_o   = r_idx;

endmodule

// File: tb/tb_digit_scan_selector.sv
// Directed bench for digit_scan_selector (DIGITS=4, DATA_W=4, DIV=4).
// Leading-zero expectations follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_digit_scan_selector;
  localparam int DIGITS = 4;
  localparam int DATA_W = 4;
  localparam int DIV    = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        load_i;
  logic [15:0] n_i;
  logic [3:0]  blank_i;
  logic [3:0]  sel_o;
  logic [3:0]  h_o;
  logic [1:0]  idx_o;
  logic        blank_o;

  digit_scan_selector #(.DIGITS(DIGITS), .DATA_W(DATA_W), .DIV(DIV)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .load_i(load_i), .n_i(n_i),
    .blank_i(blank_i), .sel_o(sel_o), .h_o(h_o), .idx_o(idx_o), .blank_o(blank_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] n;
    logic [3:0]  bl;
    int          cyc;
    logic [3:0]  sel;
    logic [3:0]  h;
    logic [1:0]  idx;
    logic        blk;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // One row = a stretch of cyc clocks with inputs held (load only on the first),
  // expected outputs checked after every clock of the stretch.
  task automatic add(input logic en, input logic ld, input logic [15:0] n, input logic [3:0] bl,
                     input int cyc, input logic [1:0] idx, input logic [3:0] h, input logic dk);
    vec_t v;
    v.en = en; v.ld = ld; v.n = n; v.bl = bl; v.cyc = cyc;
    v.idx = idx;
    v.sel = dk ? 4'b0000 : (4'b0001 << idx);
    v.h   = dk ? 4'h0 : h;
    v.blk = dk;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] s, input logic [3:0] h,
                         input logic [1:0] i, input logic b);
    chk({tag, " sel"}, 32'(sel_o), 32'(s));
    chk({tag, " h"}, 32'(h_o), 32'(h));
    chk({tag, " idx"}, 32'(idx_o), 32'(i));
    chk({tag, " blank"}, 32'(blank_o), 32'(b));
  endtask

  initial begin
    rst_ni = 1'b1; en_i = 1'b0; load_i = 1'b0; n_i = '0; blank_i = '0;

    // shadow load/scan, junk on n_i/blank_i when not loading
    add(0, 1, 16'h1234, 4'h0, 1,  0, 4'h0, 1);
    add(1, 0, 16'hFFFF, 4'hF, 3,  0, 4'h4, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  1, 4'h3, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  2, 4'h2, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  3, 4'h1, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  0, 4'h4, 0);
    // load coinciding with tick: old shadow for this dwell
    add(1, 1, 16'hABCD, 4'h0, 4,  1, 4'h3, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  2, 4'hB, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  3, 4'hA, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  0, 4'hD, 0);
    // blanking of digit 2
    add(1, 1, 16'hABCD, 4'h4, 4,  1, 4'hC, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  2, 4'h0, 1);
    add(1, 0, 16'hFFFF, 4'hF, 4,  3, 4'hA, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  0, 4'hD, 0);
    // enable drop mid-dwell of digit 1
    add(1, 0, 16'hFFFF, 4'hF, 2,  1, 4'hC, 0);
    add(0, 0, 16'hFFFF, 4'hF, 10, 1, 4'h0, 1);
    add(1, 0, 16'hFFFF, 4'hF, 2,  1, 4'hC, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  2, 4'h0, 1);
    add(1, 1, 16'h1234, 4'h0, 4,  3, 4'hA, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  0, 4'h4, 0);
    // leading zeros
    add(1, 1, 16'h0050, 4'h0, 4,  1, 4'h3, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  2, 4'h0, LZB);
    add(1, 0, 16'hFFFF, 4'hF, 4,  3, 4'h0, LZB);
    add(1, 0, 16'hFFFF, 4'hF, 4,  0, 4'h0, 0);
    add(1, 1, 16'h0000, 4'h0, 4,  1, 4'h5, 0);
    add(1, 0, 16'hFFFF, 4'hF, 4,  2, 4'h0, LZB);
    add(1, 0, 16'hFFFF, 4'hF, 4,  3, 4'h0, LZB);
    add(1, 0, 16'hFFFF, 4'hF, 4,  0, 4'h0, 0);
    add(1, 0, 16'hFFFF, 4'hF, 2,  1, 4'h0, LZB);
    // load mid-dwell does not disturb the current dwell
    add(1, 1, 16'h1234, 4'h0, 2,  1, 4'h0, LZB);
    add(1, 0, 16'hFFFF, 4'hF, 4,  2, 4'h2, 0);

    #2 rst_ni = 1'b0;
    #1 chk_out("reset", 4'b0001, 4'h0, 2'd0, 1'b0);

    @(negedge clk_i);
    rst_ni = 1'b1;
    foreach (tbl[r]) begin
      en_i = tbl[r].en; load_i = tbl[r].ld; n_i = tbl[r].n; blank_i = tbl[r].bl;
      for (int c = 0; c < tbl[r].cyc; c++) begin
        @(negedge clk_i);
        load_i = 1'b0;
        chk_out($sformatf("row%0d cyc%0d", r, c), tbl[r].sel, tbl[r].h, tbl[r].idx, tbl[r].blk);
      end
    end

    // asynchronous reset mid-frame while a load is pending
    load_i = 1'b1; n_i = 16'hFFFF; blank_i = 4'h0;
    #2 rst_ni = 1'b0;
    #1 chk_out("async_rst", 4'b0001, 4'h0, 2'd0, 1'b0);
    @(negedge clk_i);
    chk_out("rst_held", 4'b0001, 4'h0, 2'd0, 1'b0);
    rst_ni = 1'b1; load_i = 1'b0; en_i = 1'b1;
    for (int c = 0; c < DIV - 1; c++) begin
      @(negedge clk_i);
      chk_out($sformatf("post_rst cyc%0d", c), 4'b0001, 4'h0, 2'd0, 1'b0);
    end
    @(negedge clk_i);
    chk_out("post_rst tick", LZB ? 4'b0000 : 4'b0010, 4'h0, 2'd1, LZB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
